// File: rtl/lvt_multiport_ram_if.sv
// Port bundle for lvt_multiport_ram: per-port write/read buses plus status flags.
// The master side drives accesses; the slave side is the memory.
interface lvt_multiport_ram_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 512,
  parameter int WPORTS = 4,
  parameter int RPORTS = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [WPORTS-1:0]            wr_en;
  logic [WPORTS-1:0][AW-1:0]    wr_addr;
  logic [WPORTS-1:0][WIDTH-1:0] wr_data;
  logic [RPORTS-1:0]            rd_en;
  logic [RPORTS-1:0][AW-1:0]    rd_addr;
  logic [RPORTS-1:0][WIDTH-1:0] rd_data;
  logic [RPORTS-1:0]            rd_valid;
  logic                         init_busy;
  logic [WPORTS-1:0]            wr_conflict;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, init_busy, wr_conflict
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, init_busy, wr_conflict
  );
endinterface

// File: rtl/lvt_multiport_ram.sv
// Multi-port RAM from WPORTS x RPORTS 1W1R banks steered by a live value table,
// with a zeroing sweep after reset, lowest-port-wins write arbitration and 1/2-cycle reads.
module lvt_multiport_ram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 512,
  parameter int WPORTS     = 4,
  parameter int RPORTS     = 4,
  parameter int RD_LATENCY = 1,
  parameter int BYPASS     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  lvt_multiport_ram_if.slave bus
);
  localparam int              AW      = $clog2(DEPTH);
  localparam int              LW      = (WPORTS > 1) ? $clog2(WPORTS) : 1;
  localparam logic [AW:0]     DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          init, run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      INIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      default: ;
    endcase
  end

  assign init          = (state_reg == INIT);
  assign run           = (state_reg == RUN);
  assign bus.init_busy = init;

  // Write arbitration: a candidate loses to any lower-indexed candidate on the same address.
  logic [WPORTS-1:0]            cand, win, lose;
  logic [WPORTS-1:0]            bank_we;
  logic [WPORTS-1:0][AW-1:0]    bank_waddr;
  logic [WPORTS-1:0][WIDTH-1:0] bank_wdata;
  logic [WPORTS-1:0]            wr_conflict_reg;

  for (genvar gi = 0; gi < WPORTS; gi++) begin : g_cand
    assign cand[gi] = run && bus.wr_en[gi] && ({1'b0, bus.wr_addr[gi]} < DEPTH_W);
  end

  always_comb begin
    for (int w = 0; w < WPORTS; w++) begin
      win[w]  = cand[w];
      lose[w] = 1'b0;
      for (int j = 0; j < w; j++) begin
        if (cand[j] && bus.wr_addr[j] == bus.wr_addr[w]) begin
          win[w]  = 1'b0;
          lose[w] = cand[w];
        end
      end
      bank_we[w]    = init || win[w];
      bank_waddr[w] = init ? cnt_reg : bus.wr_addr[w];
      bank_wdata[w] = init ? '0 : bus.wr_data[w];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_conflict_reg <= '0;
    else        wr_conflict_reg <= lose;
  end
  assign bus.wr_conflict = wr_conflict_reg;

  // Read acceptance and same-cycle bypass from the (unique) winning writer.
  logic [RPORTS-1:0]            rd_acc, rd_ok, rd_fire, hit;
  logic [RPORTS-1:0][WIDTH-1:0] byp_data;

  for (genvar gi = 0; gi < RPORTS; gi++) begin : g_racc
    assign rd_acc[gi]  = run && bus.rd_en[gi];
    assign rd_ok[gi]   = ({1'b0, bus.rd_addr[gi]} < DEPTH_W);
    assign rd_fire[gi] = rd_acc[gi] && rd_ok[gi];
  end

  always_comb begin
    for (int r = 0; r < RPORTS; r++) begin
      hit[r]      = 1'b0;
      byp_data[r] = '0;
      for (int w = 0; w < WPORTS; w++) begin
        if (BYPASS != 0 && win[w] && bus.wr_addr[w] == bus.rd_addr[r]) begin
          hit[r]      = 1'b1;
          byp_data[r] = bus.wr_data[w];
        end
      end
    end
  end

  logic [LW-1:0]    lvt   [DEPTH];
  logic [LW-1:0]    lvt_q [RPORTS];
  logic [WIDTH-1:0] bank_q [WPORTS][RPORTS];

  always_ff @(posedge clk) begin
    if (init) lvt[cnt_reg] <= '0;
    for (int w = 0; w < WPORTS; w++)
      if (win[w]) lvt[bus.wr_addr[w]] <= LW'(w);
    for (int r = 0; r < RPORTS; r++)
      if (rd_fire[r]) lvt_q[r] <= lvt[bus.rd_addr[r]];
  end

  for (genvar gi = 0; gi < WPORTS; gi++) begin : g_wr
    for (genvar gj = 0; gj < RPORTS; gj++) begin : g_rd
      logic [WIDTH-1:0] mem [DEPTH];
      logic [WIDTH-1:0] q_reg;
      always_ff @(posedge clk) begin
        if (bank_we[gi])  mem[bank_waddr[gi]] <= bank_wdata[gi];
        if (rd_fire[gj])  q_reg <= mem[bus.rd_addr[gj]];
      end
      assign bank_q[gi][gj] = q_reg;
    end
  end

  // Stage-1 control: ok1 masks the unreset bank registers until a read has landed.
  logic [RPORTS-1:0]            v1_reg, ok1_reg, oob1_reg, hit1_reg;
  logic [RPORTS-1:0][WIDTH-1:0] byp1_reg, s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg   <= '0;
      ok1_reg  <= '0;
      oob1_reg <= '0;
      hit1_reg <= '0;
      byp1_reg <= '0;
    end else begin
      v1_reg <= rd_acc;
      for (int r = 0; r < RPORTS; r++) begin
        if (rd_acc[r]) begin
          ok1_reg[r]  <= 1'b1;
          oob1_reg[r] <= !rd_ok[r];
          hit1_reg[r] <= hit[r];
          byp1_reg[r] <= byp_data[r];
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < RPORTS; r++) begin
      s1_data[r] = '0;
      if (ok1_reg[r] && !oob1_reg[r])
        s1_data[r] = hit1_reg[r] ? byp1_reg[r] : bank_q[lvt_q[r]][r];
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [RPORTS-1:0]            v2_reg;
    logic [RPORTS-1:0][WIDTH-1:0] d2_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_reg <= '0;
        d2_reg <= '0;
      end else begin
        v2_reg <= v1_reg;
        for (int r = 0; r < RPORTS; r++)
          if (v1_reg[r]) d2_reg[r] <= s1_data[r];
      end
    end
    assign bus.rd_valid = v2_reg;
    assign bus.rd_data  = d2_reg;
  end else begin : g_lat1
    assign bus.rd_valid = v1_reg;
    assign bus.rd_data  = s1_data;
  end
endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Directed bench: three instances (bypass/lat1, no-bypass/lat1, bypass/lat2) share stimulus.
module tb_lvt_multiport_ram;
  localparam int W = 16, D = 16, NW = 4, NR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lvt_multiport_ram_if #(.WIDTH(W), .DEPTH(D), .WPORTS(NW), .RPORTS(NR)) bus_a ();
  lvt_multiport_ram_if #(.WIDTH(W), .DEPTH(D), .WPORTS(NW), .RPORTS(NR)) bus_b ();
  lvt_multiport_ram_if #(.WIDTH(W), .DEPTH(D), .WPORTS(NW), .RPORTS(NR)) bus_c ();

  assign bus_b.wr_en = bus_a.wr_en;  assign bus_c.wr_en = bus_a.wr_en;
  assign bus_b.wr_addr = bus_a.wr_addr;  assign bus_c.wr_addr = bus_a.wr_addr;
  assign bus_b.wr_data = bus_a.wr_data;  assign bus_c.wr_data = bus_a.wr_data;
  assign bus_b.rd_en = bus_a.rd_en;  assign bus_c.rd_en = bus_a.rd_en;
  assign bus_b.rd_addr = bus_a.rd_addr;  assign bus_c.rd_addr = bus_a.rd_addr;

  lvt_multiport_ram #(.WIDTH(W), .DEPTH(D), .WPORTS(NW), .RPORTS(NR), .RD_LATENCY(1), .BYPASS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  lvt_multiport_ram #(.WIDTH(W), .DEPTH(D), .WPORTS(NW), .RPORTS(NR), .RD_LATENCY(1), .BYPASS(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  lvt_multiport_ram #(.WIDTH(W), .DEPTH(D), .WPORTS(NW), .RPORTS(NR), .RD_LATENCY(2), .BYPASS(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  int n_checks = 0;
  int n_pass = 0;
  logic [W-1:0] tbl [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_a.wr_en = '0;
    bus_a.rd_en = '0;
  endtask

  task automatic read_all(input logic [3:0] a);
    for (int p = 0; p < NR; p++) bus_a.rd_addr[p] = a;
    bus_a.rd_en = '1;
  endtask

  task automatic test_reset();
    idle();
    bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.rd_addr = '0;
    rst_n = 1'b0;
    repeat (2) step();
    n_checks++; if (bus_a.init_busy !== 1'b1) $display("FAIL reset_init_busy: got %b expected 1", bus_a.init_busy); else n_pass++;
    n_checks++; if (bus_a.rd_valid !== 4'h0) $display("FAIL reset_rd_valid: got %h expected 0", bus_a.rd_valid); else n_pass++;
    n_checks++; if (bus_a.rd_data !== '0) $display("FAIL reset_rd_data: got %h expected 0", bus_a.rd_data); else n_pass++;
    n_checks++; if (bus_a.wr_conflict !== 4'h0) $display("FAIL reset_wr_conflict: got %h expected 0", bus_a.wr_conflict); else n_pass++;
    $display("reset: init_busy=%b rd_valid=%h", bus_a.init_busy, bus_a.rd_valid);
  endtask

  task automatic test_sweep();
    int cycles;
    logic seen;
    read_all(4'd0);
    bus_a.wr_en = '1;
    rst_n = 1'b1;
    cycles = 0; seen = 1'b0;
    while (bus_a.init_busy === 1'b1 && cycles < 100) begin
      step();
      cycles++;
      if (bus_a.rd_valid !== 4'h0 || bus_c.rd_valid !== 4'h0 || bus_a.wr_conflict !== 4'h0) seen = 1'b1;
    end
    n_checks++; if (cycles != D) $display("FAIL sweep_busy_cycles: got %0d expected %0d", cycles, D); else n_pass++;
    n_checks++; if (seen !== 1'b0) $display("FAIL sweep_no_valid: got %b expected 0", seen); else n_pass++;
    $display("sweep: init_busy cycles=%0d", cycles);
    idle();
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < NR; p++) bus_a.rd_addr[p] = 4'(4*k + p);
      bus_a.rd_en = '1;
      step();
      for (int p = 0; p < NR; p++) begin
        n_checks++; if (bus_a.rd_valid[p] !== 1'b1 || bus_a.rd_data[p] !== '0)
          $display("FAIL sweep_zero a port%0d: got v=%b d=%h expected v=1 d=0", p, bus_a.rd_valid[p], bus_a.rd_data[p]); else n_pass++;
        n_checks++; if (bus_b.rd_data[p] !== '0)
          $display("FAIL sweep_zero b port%0d: got %h expected 0", p, bus_b.rd_data[p]); else n_pass++;
      end
      $display("sweep read: round %0d", k);
    end
    idle(); step(); step();
  endtask

  task automatic test_crossbar();
    for (int w = 0; w < NW; w++) begin
      bus_a.wr_addr[w] = 4'(3*w);
      bus_a.wr_data[w] = 16'(16'hA0 + w);
    end
    bus_a.wr_en = '1;
    step(); idle();
    for (int k = 0; k < 4; k++) begin
      read_all(4'(3*k));
      step();
      for (int p = 0; p < NR; p++) begin
        n_checks++; if (bus_a.rd_data[p] !== 16'(16'hA0 + k))
          $display("FAIL crossbar a addr%0d port%0d: got %h expected %h", 3*k, p, bus_a.rd_data[p], 16'hA0 + k); else n_pass++;
        n_checks++; if (bus_b.rd_data[p] !== 16'(16'hA0 + k))
          $display("FAIL crossbar b addr%0d port%0d: got %h expected %h", 3*k, p, bus_b.rd_data[p], 16'hA0 + k); else n_pass++;
      end
      $display("crossbar: addr %0d read on all ports", 3*k);
    end
    idle();
    bus_a.wr_en[2] = 1'b1; bus_a.wr_addr[2] = 4'd3; bus_a.wr_data[2] = 16'hBEEF;
    step(); idle();
    read_all(4'd3);
    step(); idle();
    for (int p = 0; p < NR; p++) begin
      n_checks++; if (bus_a.rd_data[p] !== 16'hBEEF)
        $display("FAIL overwrite a port%0d: got %h expected beef", p, bus_a.rd_data[p]); else n_pass++;
    end
    step();
    n_checks++; if (bus_a.rd_valid !== 4'h0 || bus_a.rd_data[0] !== 16'hBEEF)
      $display("FAIL hold: got v=%h d=%h expected v=0 d=beef", bus_a.rd_valid, bus_a.rd_data[0]); else n_pass++;
    $display("crossbar: overwrite addr 3 with beef");
  endtask

  task automatic test_conflict();
    bus_a.wr_en = 4'b1010;
    bus_a.wr_addr[1] = 4'd7; bus_a.wr_data[1] = 16'h0011;
    bus_a.wr_addr[3] = 4'd7; bus_a.wr_data[3] = 16'h0033;
    step(); idle();
    n_checks++; if (bus_a.wr_conflict !== 4'b1000)
      $display("FAIL conflict_flag: got %b expected 1000", bus_a.wr_conflict); else n_pass++;
    read_all(4'd7);
    step(); idle();
    n_checks++; if (bus_a.wr_conflict !== 4'b0000)
      $display("FAIL conflict_one_cycle: got %b expected 0000", bus_a.wr_conflict); else n_pass++;
    for (int p = 0; p < NR; p++) begin
      n_checks++; if (bus_a.rd_data[p] !== 16'h0011)
        $display("FAIL conflict_winner port%0d: got %h expected 0011", p, bus_a.rd_data[p]); else n_pass++;
    end
    $display("conflict: addr 7 ports 1/3");
    step();
  endtask

  task automatic test_rdw();
    bus_a.wr_en[0] = 1'b1; bus_a.wr_addr[0] = 4'd5; bus_a.wr_data[0] = 16'h0055;
    step(); idle();
    bus_a.wr_en[1] = 1'b1; bus_a.wr_addr[1] = 4'd5; bus_a.wr_data[1] = 16'h0066;
    read_all(4'd5);
    step(); idle();
    for (int p = 0; p < NR; p++) begin
      n_checks++; if (bus_a.rd_data[p] !== 16'h0066)
        $display("FAIL rdw_bypass port%0d: got %h expected 0066", p, bus_a.rd_data[p]); else n_pass++;
      n_checks++; if (bus_b.rd_data[p] !== 16'h0055)
        $display("FAIL rdw_old port%0d: got %h expected 0055", p, bus_b.rd_data[p]); else n_pass++;
    end
    $display("rdw: same-cycle read of addr 5");
    read_all(4'd5);
    step(); idle();
    for (int p = 0; p < NR; p++) begin
      n_checks++; if (bus_a.rd_data[p] !== 16'h0066 || bus_b.rd_data[p] !== 16'h0066)
        $display("FAIL rdw_after port%0d: got a=%h b=%h expected 0066", p, bus_a.rd_data[p], bus_b.rd_data[p]); else n_pass++;
    end
    $display("rdw: next-cycle read of addr 5");
    step(); step();
  endtask

  task automatic test_latency();
    tbl[0] = 16'h00A0; tbl[1] = 16'hBEEF; tbl[2] = 16'h00A2; tbl[3] = 16'h00A3;
    for (int j = 1; j <= 7; j++) begin
      if (j <= 6) begin
        for (int p = 0; p < NR; p++) bus_a.rd_addr[p] = 4'(3*((j + p) % 4));
        bus_a.rd_en = '1;
      end else begin
        idle();
      end
      step();
      n_checks++; if (bus_c.rd_valid !== ((j >= 2) ? 4'hF : 4'h0))
        $display("FAIL latency_valid edge%0d: got %h expected %h", j, bus_c.rd_valid, (j >= 2) ? 4'hF : 4'h0); else n_pass++;
      if (j >= 2) begin
        for (int p = 0; p < NR; p++) begin
          n_checks++; if (bus_c.rd_data[p] !== tbl[(j - 1 + p) % 4])
            $display("FAIL latency_data edge%0d port%0d: got %h expected %h", j, p, bus_c.rd_data[p], tbl[(j - 1 + p) % 4]); else n_pass++;
        end
      end
      if (j == 1) begin
        n_checks++; if (bus_a.rd_valid !== 4'hF || bus_a.rd_data[0] !== tbl[1])
          $display("FAIL latency1: got v=%h d=%h expected v=f d=%h", bus_a.rd_valid, bus_a.rd_data[0], tbl[1]); else n_pass++;
      end
      $display("latency: edge %0d c.rd_valid=%h", j, bus_c.rd_valid);
    end
    step();
    n_checks++; if (bus_c.rd_valid !== 4'h0)
      $display("FAIL latency_end: got %h expected 0", bus_c.rd_valid); else n_pass++;
  endtask

  task automatic test_reset_midop();
    int cycles;
    logic seen;
    bus_a.wr_en[0] = 1'b1; bus_a.wr_addr[0] = 4'd2; bus_a.wr_data[0] = 16'h0099;
    step(); idle();
    read_all(4'd2);
    step(); idle();
    n_checks++; if (bus_a.rd_data[0] !== 16'h0099)
      $display("FAIL midop_write: got %h expected 0099", bus_a.rd_data[0]); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus_c.rd_valid !== 4'h0 || bus_a.rd_valid !== 4'h0)
      $display("FAIL midop_flush: got a=%h c=%h expected 0", bus_a.rd_valid, bus_c.rd_valid); else n_pass++;
    n_checks++; if (bus_a.init_busy !== 1'b1)
      $display("FAIL midop_busy: got %b expected 1", bus_a.init_busy); else n_pass++;
    step();
    rst_n = 1'b1;
    cycles = 0; seen = 1'b0;
    while (bus_a.init_busy === 1'b1 && cycles < 100) begin
      step();
      cycles++;
      if (bus_c.rd_valid !== 4'h0) seen = 1'b1;
    end
    n_checks++; if (cycles != D || seen !== 1'b0)
      $display("FAIL midop_sweep: got cycles=%0d valid_seen=%b expected %0d/0", cycles, seen, D); else n_pass++;
    read_all(4'd2);
    step(); idle();
    n_checks++; if (bus_a.rd_valid[0] !== 1'b1 || bus_a.rd_data[0] !== '0)
      $display("FAIL midop_zero a: got v=%b d=%h expected v=1 d=0", bus_a.rd_valid[0], bus_a.rd_data[0]); else n_pass++;
    step();
    n_checks++; if (bus_c.rd_valid[0] !== 1'b1 || bus_c.rd_data[0] !== '0)
      $display("FAIL midop_zero c: got v=%b d=%h expected v=1 d=0", bus_c.rd_valid[0], bus_c.rd_data[0]); else n_pass++;
    $display("reset mid-op: sweep cycles=%0d addr 2=%h", cycles, bus_a.rd_data[0]);
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_crossbar();
    test_conflict();
    test_rdw();
    test_latency();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
